imm_acc_alu: RTL

//   Accumulator ALU directly downstream of the signextender stage.

---
 rtl/imm_acc_alu.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imm_acc_alu.sv
// Accumulator ALU fed by the sign-extended immediate: single-cycle logic/arith ops plus a
// WIDTH-cycle shift-add multiply. Define SATURATE_EN to clamp ADD/SUB on signed overflow.
module imm_acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       flags,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpXor  = 3'b101;
  localparam logic [2:0] OpMul  = 3'b110;
  localparam logic [2:0] OpClr  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res, step;
  logic             resC, resV;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == MUL);
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign done     = done_q;

  assign sum  = {1'b0, acc_q} + {1'b0, operand};
  assign diff = {1'b0, acc_q} - {1'b0, operand};
  assign step = mplier_q[cnt_q] ? partial_q + (mcand_q << cnt_q) : partial_q;

  // Result and carry/overflow of the single-cycle ops; C always comes from the raw result.
  always_comb begin
    res  = '0;
    resC = 1'b0;
    resV = 1'b0;
    case (op)
      OpLoad: res = operand;
      OpAdd: begin
        res  = sum[WIDTH-1:0];
        resC = sum[WIDTH];
        resV = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpSub: begin
        res  = diff[WIDTH-1:0];
        resC = diff[WIDTH];
        resV = (acc_q[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpAnd:   res = acc_q & operand;
      OpOr:    res = acc_q | operand;
      OpXor:   res = acc_q ^ operand;
      OpClr:   res = '0;
      default: res = '0;
    endcase
`ifdef SATURATE_EN
    // Overflow direction follows the sign of acc for both ADD and SUB.
    if (resV) begin
      res = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OpMul) begin
            state_d   = MUL;
            mcand_d   = acc_q;
            mplier_d  = operand;
            partial_d = '0;
            cnt_d     = '0;
          end else begin
            acc_d   = res;
            flags_d = {(res == '0), res[WIDTH-1], resC, resV};
            done_d  = 1'b1;
          end
        end
      end
      MUL: begin
        partial_d = step;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          acc_d   = step;
          flags_d = {(step == '0), step[WIDTH-1], 2'b00};
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
